mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 Parameter BURST_LEN, default 4, range 1..16: max beats per grant before re-arbitration.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  16  per-requester request; req[i] held high while requester i has data.
REQ-005 in  input  16  per-requester data bit; in[i] belongs to requester i.
REQ-006 out_ready  input  1  downstream accepts a beat this cycle.
REQ-007 sel  output  4  registered select index of current owner (drives the 16:1 datapath).
REQ-008 gnt  output  16  registered one-hot grant; all-zero when idle.
REQ-009 out  output  1  in[sel], combinational from registered sel.
REQ-010 out_valid  output  1  beat offered: high only in XFER with req[sel]=1.
REQ-011 done  output  1  one-cycle pulse on the cycle a grant is released.

Function
REQ-012 FSM states IDLE, XFER only; beat = out_valid && out_ready.
REQ-013 IDLE, req!=0: search from ptr+1 upward, wrap 15->0, first set bit wins; next edge: sel=winner, gnt=1<<winner, ptr=winner, beat_cnt=0, state=XFER.
REQ-014 IDLE, req==0: hold sel, ptr; gnt=0.
REQ-015 Arbitration latency: exactly one cycle from req visible in IDLE to gnt/out_valid high.
REQ-016 XFER: each beat increments beat_cnt; beat with beat_cnt==BURST_LEN-1 -> IDLE next edge, done=1 that edge.
REQ-017 XFER, req[sel]=0: no beat; next edge -> IDLE, done=1 (early release, partial burst).
REQ-018 XFER, out_ready=0: hold state, sel, gnt, beat_cnt (backpressure, no timeout).
REQ-019 One-cycle IDLE bubble after every release; gnt=0 during it; no back-to-back grants.
REQ-020 Requests other than req[sel] ignored during XFER; no preemption.
REQ-021 beat_cnt width 5 bits; BURST_LEN=16 releases after 16th beat, no overflow.
REQ-022 sel holds last owner in IDLE; out keeps tracking in[sel] but out_valid=0.
REQ-023 Fairness: with all 16 requesting continuously, grant order 0,1,...,15,0, each granted once per 16 grants.

Reset
REQ-024 rst_n low asynchronously forces: state=IDLE, gnt=0, sel=0, out_valid=0, done=0, beat_cnt=0, ptr=15.
REQ-025 Reset mid-XFER aborts burst immediately with no done pulse; first post-reset search starts at requester 0.
REQ-026 Deassertion of rst_n is synchronised externally; first arbitration on first edge after release.

Configuration
REQ-027 Macro MUX16_SCHED_PRIO0_EN selects fixed priority for requester 0.
REQ-028 Defined: in IDLE, req[0]=1 wins regardless of ptr, and ptr is NOT updated by a requester-0 grant; other requesters arbitrate per REQ-013.
REQ-029 Not defined: requester 0 is an ordinary round-robin participant per REQ-013; no logic for the override is synthesised.

Verification
REQ-030 Reset, req=16'h0001, out_ready=1, in[0]=1, BURST_LEN=4 -> gnt=16'h0001, sel=0 one cycle later; 4 beats with out=1; done on 4th; IDLE one cycle; regrant to 0.
REQ-031 req=16'hFFFF held, out_ready=1 -> sel sequence 0,1,2,...,15,0, each burst 4 beats, each separated by one idle cycle.
REQ-032 Owner 5 in XFER, beat 2, req[5] drops -> out_valid=0 same cycle, done next edge, IDLE; ptr=5, next search starts at 6.
REQ-033 Owner 3, out_ready=0 for 10 cycles -> sel=3, gnt=16'h0008, beat_cnt frozen; on out_ready=1 burst completes remaining beats.
REQ-034 rst_n pulsed low mid-burst of owner 9 -> gnt=0, out_valid=0 same cycle, no done; afterwards req=16'h0201 grants 0 first.
REQ-035 MUX16_SCHED_PRIO0_EN defined, req=16'h0011 held -> grants 0,0,0,...; ptr stays 15; dropping req[0] then grants 4.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: 16-requester round-robin burst scheduler driving a 16:1
// single-bit datapath. An owner keeps the grant for up to BURST_LEN beats,
// then the scheduler spends one idle cycle re-arbitrating before the next grant.
// Optional build macro MUX16_SCHED_PRIO0_EN: requester 0 wins every idle
// arbitration and its grants leave the round-robin pointer untouched.
//
// Handshake: a beat moves when out_valid && out_ready on a rising clk edge.
// out_valid depends only on the scheduler state and req[sel], never on
// out_ready. Once raised, it stays high until the beat is taken, or until the
// owner drops req[sel], which releases the grant early.
module mux16_rr_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        out,
    output logic        out_valid,
    output logic        done,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Last beat index of a burst; 5 bits so BURST_LEN=16 fits without wrap
    localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

    state_t      state;
    logic [3:0]  ptr;
    logic [4:0]  beat_cnt;
    logic [3:0]  rr_idx;
    logic        rr_found;
    logic [3:0]  cand;
    logic [3:0]  winner;
    logic        beat;

    // Round-robin search: first set request strictly after ptr, wrapping 15->0
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        cand     = '0;
        for (int i = 1; i <= 16; i++) begin
            cand = ptr + 4'(i);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Pick the idle-state winner, optionally letting requester 0 override
    always_comb begin
`ifdef MUX16_SCHED_PRIO0_EN
        winner = req[0] ? 4'd0 : rr_idx;
`else
        winner = rr_idx;
`endif
    end

    assign out_valid = (state == XFER) && req[sel];
    assign beat      = out_valid && out_ready;
    assign out       = in[sel];
    assign dbg_state = state;

    // Scheduler FSM with registered sel/gnt/done, pointer and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            done     <= 1'b0;
            beat_cnt <= '0;
            ptr      <= 4'd15;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= winner;
                        gnt      <= 16'h0001 << winner;
                        beat_cnt <= '0;
                        state    <= XFER;
`ifdef MUX16_SCHED_PRIO0_EN
                        // A priority grant to requester 0 must not disturb fairness
                        if (!req[0]) ptr <= winner;
`else
                        ptr <= winner;
`endif
                    end else begin
                        gnt <= '0;
                    end
                end
                XFER: begin
                    if (!req[sel]) begin
                        // Owner ran out of data: release with a partial burst
                        state <= IDLE;
                        gnt   <= '0;
                        done  <= 1'b1;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 5'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            gnt   <= '0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: directed bench for mux16_rr_sched with BURST_LEN=4.
module tb_mux16_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] in;
    logic        out_ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        out;
    logic        out_valid;
    logic        done;
    logic        dbg_state;

    int checks;
    int errors;

    mux16_rr_sched #(.BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in        (in),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset pulse, released 1 unit after a rising edge
    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        in        = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        in     = '0;
        out_ready = 1'b0;

        // ---- Reset state
        do_reset();
        chk("rst_gnt",   gnt, 16'h0000);
        chk("rst_sel",   16'(sel), 16'h0000);
        chk("rst_valid", 16'(out_valid), 16'h0000);
        chk("rst_done",  16'(done), 16'h0000);
        chk("rst_state", 16'(dbg_state), 16'h0000);
        chk("rst_ptr",   16'(dut.ptr), 16'h000F);
        chk("rst_cnt",   16'(dut.beat_cnt), 16'h0000);

        // ---- Single requester 0: one-cycle latency, 4 beats, bubble, regrant
        req = 16'h0001; in = 16'h0001; out_ready = 1'b1;
        chk("r0_no_early_gnt", gnt, 16'h0000);
        tick();
        chk("r0_gnt", gnt, 16'h0001);
        chk("r0_sel", 16'(sel), 16'h0000);
        for (int b = 0; b < 4; b++) begin
            chk("r0_valid", 16'(out_valid), 16'h0001);
            chk("r0_out", 16'(out), 16'h0001);
            chk("r0_no_done", 16'(done), 16'h0000);
            tick();
        end
        chk("r0_done", 16'(done), 16'h0001);
        chk("r0_bubble_gnt", gnt, 16'h0000);
        chk("r0_bubble_valid", 16'(out_valid), 16'h0000);
        chk("r0_bubble_state", 16'(dbg_state), 16'h0000);
        tick();
        chk("r0_regrant", gnt, 16'h0001);
        chk("r0_done_pulse", 16'(done), 16'h0000);

        // ---- All requesting: fairness order 0..15,0 with one idle cycle between
`ifndef MUX16_SCHED_PRIO0_EN
        do_reset();
        req = 16'hFFFF; in = 16'hA5C3; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("rr_sel", 16'(sel), 16'(k % 16));
            chk("rr_gnt", gnt, 16'h0001 << (k % 16));
            for (int b = 0; b < 4; b++) begin
                chk("rr_valid", 16'(out_valid), 16'h0001);
                tick();
            end
            chk("rr_done", 16'(done), 16'h0001);
            chk("rr_bubble", gnt, 16'h0000);
        end
        chk("rr_out_idle", 16'(out), 16'(1'b1));
`else
        // ---- Requester 0 fixed priority
        do_reset();
        req = 16'h0011; in = '0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("p0_sel", 16'(sel), 16'h0000);
            chk("p0_ptr", 16'(dut.ptr), 16'h000F);
            for (int b = 0; b < 4; b++) tick();
            chk("p0_done", 16'(done), 16'h0001);
        end
        tick();
        chk("p0_sel4", 16'(sel), 16'h0000);
        req = 16'h0010;
        #1;
        chk("p0_drop_valid", 16'(out_valid), 16'h0000);
        tick();
        chk("p0_drop_done", 16'(done), 16'h0001);
        tick();
        chk("p0_grant4", 16'(sel), 16'h0004);
        chk("p0_ptr4", 16'(dut.ptr), 16'h0004);
`endif

        // ---- Early release: owner 5 drops req at beat 2
        do_reset();
        req = 16'h0020; in = '0; out_ready = 1'b1;
        tick();
        chk("er_sel", 16'(sel), 16'h0005);
        tick();
        tick();
        chk("er_cnt", 16'(dut.beat_cnt), 16'h0002);
        req = 16'h0000;
        #1;
        chk("er_valid_drop", 16'(out_valid), 16'h0000);
        chk("er_no_done_yet", 16'(done), 16'h0000);
        tick();
        chk("er_done", 16'(done), 16'h0001);
        chk("er_gnt", gnt, 16'h0000);
        chk("er_ptr", 16'(dut.ptr), 16'h0005);
        chk("er_sel_hold", 16'(sel), 16'h0005);
        in = 16'h0020;
        #1;
        chk("er_out_track", 16'(out), 16'h0001);
        chk("er_idle_valid", 16'(out_valid), 16'h0000);
        req = 16'h0042;
        tick();
        chk("er_next6", 16'(sel), 16'h0006);
        chk("er_next6_gnt", gnt, 16'h0040);

        // ---- Backpressure: owner 3 stalled 10 cycles after one beat
        do_reset();
        req = 16'h0008; in = '0; out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_sel", 16'(sel), 16'h0003);
            chk("bp_gnt", gnt, 16'h0008);
            chk("bp_cnt", 16'(dut.beat_cnt), 16'h0001);
            chk("bp_valid", 16'(out_valid), 16'h0001);
        end
        out_ready = 1'b1;
        tick();
        tick();
        chk("bp_cnt3", 16'(dut.beat_cnt), 16'h0003);
        chk("bp_no_done", 16'(done), 16'h0000);
        tick();
        chk("bp_done", 16'(done), 16'h0001);
        chk("bp_release", gnt, 16'h0000);

        // ---- Reset mid-burst of owner 9
        do_reset();
        req = 16'h0200; in = '0; out_ready = 1'b1;
        tick();
        chk("mr_sel", 16'(sel), 16'h0009);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", gnt, 16'h0000);
        chk("mr_valid", 16'(out_valid), 16'h0000);
        chk("mr_done", 16'(done), 16'h0000);
        tick();
        chk("mr_done_hold", 16'(done), 16'h0000);
        rst_n = 1'b1;
        req = 16'h0201;
        #1;
        chk("mr_idle_gnt", gnt, 16'h0000);
        tick();
        chk("mr_first0", 16'(sel), 16'h0000);
        chk("mr_first0_gnt", gnt, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
